nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor: Diff = A - B - Bin, computed one 4-bit
//  nibble per clock, LSB nibble first. Each nibble uses a carry-lookahead slice
//  on A + ~B, with carry-in = ~borrow; the borrow ripples between cycles in a register.
//  It is the subtract-side counterpart of the team's 4-bit CLA adder.
//  It serves the datapath where area matters more than latency.
//  Ready/valid handshake on both input and output.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 4.
//             Elaboration error otherwise.
// PORTS
//  clk        in   1      rising-edge clock (one clock domain)
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      A/B/Bin valid
//  in_ready   out  1      block can accept operands
//  A          in   WIDTH  minuend
//  B          in   WIDTH  subtrahend
//  Bin        in   1      borrow-in
//  out_valid  out  1      Diff/Bout valid
//  out_ready  in   1      consumer accepts result
//  Diff       out  WIDTH  A - B - Bin mod 2^WIDTH
//  Bout       out  1      borrow-out: 1 iff A < B + Bin (unsigned)
//  Ovf        out  1      signed overflow (present only with NSS_OVF_EN)
// BEHAVIOUR
//  - Reset (rst_n=0): state=IDLE, in_ready=0 while rst_n low, out_valid=0,
//    Diff=0, Bout=0, Ovf=0, nibble counter=0. Any in-flight operation is
//    discarded; no output is produced for it.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready, latch A, B and Bin.
//    Load borrow reg=Bin, counter=0, go RUN.
//  - RUN: in_ready=0. Each cycle k (k=0..WIDTH/4-1) computes nibble k:
//    {c,d} = A[4k+3:4k] + ~B[4k+3:4k] + ~borrow, using a G/P lookahead slice.
//    Write d into Diff[4k+3:4k] and set borrow = ~c.
//    On the last nibble, go DONE.
//  - DONE: out_valid=1. Diff, Bout and Ovf are held stable until
//    out_valid&out_ready; then return to IDLE.
//  - Latency: operands accepted at edge t -> out_valid high after edge
//    t+WIDTH/4 (4 cycles at WIDTH=16). Throughput: one op per WIDTH/4+2
//    cycles minimum (IDLE and DONE each last at least one cycle).
//  - Diff is not a valid result until out_valid. Bits are overwritten nibble
//    by nibble during RUN and must not be consumed.
//  - Holding out_ready=1 early has no effect outside DONE.
//  - in_valid is ignored outside IDLE. Operands are captured once;
//    A, B and Bin may change freely during RUN.
//  - Boundary cases: B=0,Bin=0 -> Diff=A, Bout=0. A=B,Bin=1 -> Diff=all-ones,
//    Bout=1. WIDTH=4 -> RUN lasts exactly one cycle.
// CONFIGURATION
//  NSS_OVF_EN defined: adds port Ovf, registered at the last nibble.
//    Ovf = (A[W-1]!=B[W-1]) & (Diff[W-1]!=A[W-1]), i.e. two's-complement
//    overflow of A-B-Bin. Ovf is held with Diff in DONE.
//  NSS_OVF_EN undefined: the Ovf port and its logic are absent.
//    All other behaviour is identical.
// TESTING (WIDTH=16)
//  1 A=0x1234,B=0x0234,Bin=0 -> out_valid 4 cycles after accept,
//    Diff=0x1000, Bout=0
//  2 A=0x0000,B=0x0001,Bin=0 -> Diff=0xFFFF, Bout=1
//    (borrow ripples through all 4 nibbles)
//  3 A=0x0010,B=0x000F,Bin=1 -> Diff=0x0000, Bout=0
//    A=0x0005,B=0x0005,Bin=1 -> Diff=0xFFFF, Bout=1
//  4 [NSS_OVF_EN] A=0x8000,B=0x0001 -> Diff=0x7FFF, Ovf=1, Bout=0
//    A=0x7FFF,B=0xFFFF -> Diff=0x8000, Ovf=1
//  5 Backpressure: hold out_ready=0 for 5 cycles in DONE -> Diff/Bout stable,
//    in_ready=0. Toggle in_valid and A meanwhile -> no capture.
//    Release out_ready -> IDLE next cycle.
//  6 Assert rst_n=0 during RUN nibble 2 -> all outputs 0 immediately
//    (async). After release, a new op 0x0003-0x0001 gives Diff=0x0002.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: Diff = A - B - Bin, one 4-bit CLA slice per clock, LSB first.
// Optional signed-overflow output Ovf is enabled by defining NSS_OVF_EN.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
`ifdef NSS_OVF_EN
  output logic             Ovf,
`endif
  output logic             Bout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             bout_q;
`ifdef NSS_OVF_EN
  logic             ovf_q;
`endif

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] d_nib;
  logic       c_out;

  // 4-bit generate/propagate lookahead slice; returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Subtraction as A + ~B + ~borrow; the slice carry-out is the inverted borrow.
  always_comb begin
    a_nib          = a_q[{cnt_q, 2'b00} +: 4];
    b_nib          = b_q[{cnt_q, 2'b00} +: 4];
    {c_out, d_nib} = cla4(a_nib, ~b_nib, ~borrow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
`ifdef NSS_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          diff_q[{cnt_q, 2'b00} +: 4] <= d_nib;
          borrow_q <= ~c_out;
          if (cnt_q == LAST) begin
            bout_q  <= ~c_out;
`ifdef NSS_OVF_EN
            ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_nib[3] ^ a_q[WIDTH-1]);
`endif
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // in_ready must drop immediately while reset is asserted, hence the rst_n term.
  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_DONE);
  assign Diff      = diff_q;
  assign Bout      = bout_q;
`ifdef NSS_OVF_EN
  assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor at WIDTH=16 (Ovf checks with NSS_OVF_EN).
module tb_nibble_serial_subtractor;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef NSS_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .Bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (diff),
`ifdef NSS_OVF_EN
    .Ovf      (ovf),
`endif
    .Bout     (bout)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin);
    exp_t       e;
    logic [W:0] r;
    r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.ovf  = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    return e;
  endfunction

  // Drive one operand set at a negedge where in_ready is high; push expectation.
  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb_, input logic sbin);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (!in_ready) begin
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
      n_err++;
    end
    in_valid = 1'b1;
    a        = sa;
    b        = sb_;
    bin      = sbin;
    sb.push_back(model(sa, sb_, sbin));
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom_range(0, 65535);
    b        = $urandom_range(0, 65535);
    bin      = 1'($urandom_range(0, 1));
  endtask

  // Called right after send: wait for out_valid, check latency and result, then consume.
  task automatic recv(input string name);
    int   cycles;
    exp_t e;
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    e = sb.pop_front();
    n_vec++;
    if (!out_valid) begin
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles", name, cycles);
      n_err++;
      return;
    end
    if (cycles !== NIB + 1) begin
      $display("FAIL %s_latency: got %0d negedges required %0d", name, cycles, NIB + 1);
      n_err++;
    end
    n_vec++;
    if (diff !== e.diff || bout !== e.bout) begin
      $display("FAIL %s_result: Diff=%h Bout=%0b required Diff=%h Bout=%0b",
               name, diff, bout, e.diff, e.bout);
      n_err++;
    end
`ifdef NSS_OVF_EN
    n_vec++;
    if (ovf !== e.ovf) begin
      $display("FAIL %s_ovf: Ovf=%0b required %0b", name, ovf, e.ovf);
      n_err++;
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s_return_idle: out_valid=%0b in_ready=%0b required 0/1",
               name, out_valid, in_ready);
      n_err++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b Diff=%h Bout=%0b required 0/0/0000/0",
               in_ready, out_valid, diff, bout);
      n_err++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
      n_err++;
    end
  endtask

  task automatic test_basic();
    send(16'h1234, 16'h0234, 1'b0); recv("v1_1234");
    send(16'h0000, 16'h0001, 1'b0); recv("v2_ripple");
    send(16'h0010, 16'h000F, 1'b1); recv("v3_bin");
    send(16'h0005, 16'h0005, 1'b1); recv("v3_eq_bin");
    send(16'hABCD, 16'h0000, 1'b0); recv("b_zero");
    send(16'hFFFF, 16'hFFFF, 1'b0); recv("ones_eq");
  endtask

  task automatic test_ovf();
    send(16'h8000, 16'h0001, 1'b0); recv("ovf_neg");
    send(16'h7FFF, 16'hFFFF, 1'b0); recv("ovf_pos");
    send(16'h7FFF, 16'h0001, 1'b0); recv("no_ovf");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0;
    logic         b0;
    exp_t         e;
    out_ready = 1'b0;
    send(16'h4321, 16'h1111, 1'b0);
    repeat (NIB) @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || diff !== e.diff || bout !== e.bout) begin
      $display("FAIL bp_result: out_valid=%0b Diff=%h Bout=%0b required 1 %h %0b",
               out_valid, diff, bout, e.diff, e.bout);
      n_err++;
    end
    d0 = diff;
    b0 = bout;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a        = a + 16'h0101;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== d0 || bout !== b0) begin
        $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b Diff=%h Bout=%0b required 1/0/%h/%0b",
                 i, out_valid, in_ready, diff, bout, d0, b0);
        n_err++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      n_err++;
    end
  endtask

  task automatic test_reset_midrun();
    send(16'hFFFF, 16'h0000, 1'b0);
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      $display("FAIL midrun_reset: in_ready=%0b out_valid=%0b Diff=%h Bout=%0b required 0/0/0000/0",
               in_ready, out_valid, diff, bout);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NIB + 2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL midrun_discard: out_valid=%0b required 0", out_valid);
      n_err++;
    end
    send(16'h0003, 16'h0001, 1'b0); recv("after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)));
      recv("rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef NSS_OVF_EN
    test_ovf();
`endif
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
